// File: rtl/wsc_monitor.sv
// Rule checker for the wolf/sheep/cabbage crossing engine: validates each move, counts legal moves, registers a verdict.
// Optional WSC_MON_REVISIT_EN builds a visited-state bitmap that drives the sticky revisit flag.
module wsc_monitor #(
  parameter int MOVE_W    = 4,
  parameter int MAX_MOVES = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clear,
  input  logic [3:0]        state_in,
  output logic [1:0]        status,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [MOVE_W-1:0] moves,
  output logic              revisit
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2, FAIL = 2'd3} mon_state_t;

  localparam logic [1:0]        ERR_NONE    = 2'd0;
  localparam logic [1:0]        ERR_ILLEGAL = 2'd1;
  localparam logic [1:0]        ERR_EATEN   = 2'd2;
  localparam logic [1:0]        ERR_BUDGET  = 2'd3;
  localparam logic [MOVE_W-1:0] MOVE_SAT    = '1;
  localparam logic [MOVE_W-1:0] BUDGET      = MOVE_W'(MAX_MOVES);

  mon_state_t        state_q, state_d;
  logic [1:0]        err_q, err_d;
  logic [MOVE_W-1:0] moves_q, moves_d, moves_inc;
  logic [3:0]        prev_q, prev_d;
  logic              done_q, error_q;

  logic [3:0] toggled;
  logic [2:0] item_tog;
  logic       illegal, eaten;

  // A legal crossing toggles the farmer plus at most one item that stood on the farmer's bank.
  assign toggled   = state_in ^ prev_q;
  assign item_tog  = toggled[2:0];
  assign illegal   = !toggled[3]
                   || ((item_tog & (item_tog - 3'd1)) != 3'd0)
                   || ((item_tog & (prev_q[2:0] ^ {3{prev_q[3]}})) != 3'd0);
  assign eaten     = ((state_in[2] == state_in[1]) && (state_in[3] != state_in[1]))
                   || ((state_in[1] == state_in[0]) && (state_in[3] != state_in[1]));
  assign moves_inc = (moves_q == MOVE_SAT) ? moves_q : moves_q + 1'b1;

`ifdef WSC_MON_REVISIT_EN
  logic [15:0] visited_q, visited_d;
  logic        revisit_q, revisit_d;
`endif

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    moves_d = moves_q;
    prev_d  = prev_q;
`ifdef WSC_MON_REVISIT_EN
    visited_d = visited_q;
    revisit_d = revisit_q;
`endif
    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (state_in == 4'h0) begin
            state_d = RUN;
            prev_d  = 4'h0;
`ifdef WSC_MON_REVISIT_EN
            visited_d[0] = 1'b1;
`endif
          end
        end
        RUN: begin
          if (state_in != prev_q) begin
            if (illegal) begin
              state_d = FAIL;
              err_d   = ERR_ILLEGAL;
            end else if (eaten) begin
              state_d = FAIL;
              err_d   = ERR_EATEN;
            end else begin
              moves_d = moves_inc;
              prev_d  = state_in;
`ifdef WSC_MON_REVISIT_EN
              visited_d[state_in] = 1'b1;
              if (visited_q[state_in]) revisit_d = 1'b1;
`endif
              // Reaching the far bank wins over a budget hit on the same move.
              if (state_in == 4'hF) begin
                state_d = DONE;
              end else if (moves_inc == BUDGET) begin
                state_d = FAIL;
                err_d   = ERR_BUDGET;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q <= IDLE;
      err_q   <= ERR_NONE;
      moves_q <= '0;
      prev_q  <= 4'h0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      moves_q <= moves_d;
      prev_q  <= prev_d;
      done_q  <= (state_d == DONE);
      error_q <= (state_d == FAIL);
    end
  end

`ifdef WSC_MON_REVISIT_EN
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      visited_q <= 16'h0000;
      revisit_q <= 1'b0;
    end else begin
      visited_q <= visited_d;
      revisit_q <= revisit_d;
    end
  end
  assign revisit = revisit_q;
`else
  assign revisit = 1'b0;
`endif

  assign status   = state_q;
  assign done     = done_q;
  assign error    = error_q;
  assign err_code = err_q;
  assign moves    = moves_q;

endmodule

// File: tb/tb_wsc_monitor.sv
// Bench for wsc_monitor: two instances (default budget and budget 3) share stimulus; a rule-level model
// is compared every cycle, and directed literal checks pin the model to hand-computed results.
module tb_wsc_monitor;

  localparam int W = 11;

  logic       clk = 1'b0;
  logic       rst, clear, en;
  logic [3:0] state_in;

  logic [1:0] status_a, err_code_a, status_b, err_code_b;
  logic       done_a, error_a, revisit_a, done_b, error_b, revisit_b;
  logic [3:0] moves_a, moves_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wsc_monitor #(.MOVE_W(4), .MAX_MOVES(15)) dut_a (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .state_in(state_in),
    .status(status_a), .done(done_a), .error(error_a), .err_code(err_code_a),
    .moves(moves_a), .revisit(revisit_a)
  );

  wsc_monitor #(.MOVE_W(4), .MAX_MOVES(3)) dut_b (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .state_in(state_in),
    .status(status_b), .done(done_b), .error(error_b), .err_code(err_code_b),
    .moves(moves_b), .revisit(revisit_b)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    int          st;    // 0 idle, 1 run, 2 done, 3 fail
    int          ec;
    int          mv;
    logic [3:0]  prev;
    logic [15:0] vis;
    logic        rv;
  } model_t;

  model_t ma = '{st: 0, ec: 0, mv: 0, prev: 4'h0, vis: 16'h0, rv: 1'b0};
  model_t mb = '{st: 0, ec: 0, mv: 0, prev: 4'h0, vis: 16'h0, rv: 1'b0};

  logic [W-1:0] exp_qa[$];
  logic [W-1:0] exp_qb[$];

  function automatic model_t model_step(model_t m, int max_moves, logic r, logic c, logic e,
                                        logic [3:0] s);
    logic [3:0] d;
    int items;
    bit wrong, bad_move, ate;
    if (r || c) begin
      m = '{st: 0, ec: 0, mv: 0, prev: 4'h0, vis: 16'h0, rv: 1'b0};
      return m;
    end
    if (!e) return m;
    if (m.st == 0) begin
      if (s == 4'h0) begin
        m.st = 1;
        m.prev = 4'h0;
        m.vis[0] = 1'b1;
      end
    end else if (m.st == 1 && s != m.prev) begin
      d = s ^ m.prev;
      items = 0;
      wrong = 0;
      for (int i = 0; i < 3; i++) begin
        if (d[i]) begin
          items++;
          if (m.prev[i] != m.prev[3]) wrong = 1;
        end
      end
      bad_move = !d[3] || items > 1 || wrong;
      ate = (s[2] == s[1] && s[3] != s[1]) || (s[1] == s[0] && s[3] != s[1]);
      if (bad_move) begin
        m.st = 3; m.ec = 1;
      end else if (ate) begin
        m.st = 3; m.ec = 2;
      end else begin
        if (m.mv < 15) m.mv++;
        m.prev = s;
        if (m.vis[s]) m.rv = 1'b1;
        m.vis[s] = 1'b1;
        if (s == 4'hF) m.st = 2;
        else if (m.mv == max_moves) begin
          m.st = 3; m.ec = 3;
        end
      end
    end
    return m;
  endfunction

  function automatic logic [W-1:0] pack(model_t m);
    logic rv_exp;
`ifdef WSC_MON_REVISIT_EN
    rv_exp = m.rv;
`else
    rv_exp = 1'b0;
`endif
    return {2'(m.st), (m.st == 2), (m.st == 3), 2'(m.ec), 4'(m.mv), rv_exp};
  endfunction

  always @(posedge clk) begin
    ma = model_step(ma, 15, rst, clear, en, state_in);
    mb = model_step(mb, 3, rst, clear, en, state_in);
    exp_qa.push_back(pack(ma));
    exp_qb.push_back(pack(mb));
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic [W-1:0] exp_v, act_v;
    if (exp_qa.size() > 0) begin
      exp_v = exp_qa.pop_front();
      act_v = {status_a, done_a, error_a, err_code_a, moves_a, revisit_a};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL cycle_a t=%0t got=%b expected=%b", $time, act_v, exp_v);
      end
    end
    if (exp_qb.size() > 0) begin
      exp_v = exp_qb.pop_front();
      act_v = {status_b, done_b, error_b, err_code_b, moves_b, revisit_b};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL cycle_b t=%0t got=%b expected=%b", $time, act_v, exp_v);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp_v);
    end
  endtask

  task automatic step(input logic e, input logic [3:0] s);
    @(negedge clk);
    en = e;
    state_in = s;
  endtask

  task automatic settle();
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic do_reset(input logic use_clear, input logic use_rst);
    @(negedge clk);
    rst = use_rst;
    clear = use_clear;
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    clear = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    rst = 1'b1;
    clear = 1'b0;
    en = 1'b0;
    state_in = 4'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_status", status_a, 0);
    chk("reset_moves", moves_a, 0);
    chk("reset_done", done_a, 0);
    chk("reset_error", error_a, 0);
    chk("reset_err_code", err_code_a, 0);
    chk("reset_revisit", revisit_a, 0);

    // Non-zero sample in IDLE is ignored.
    step(1, 4'h5); settle();
    chk("idle_nonzero_status", status_a, 0);
    chk("idle_nonzero_error", error_a, 0);

    // Full solution; the verdict appears one cycle after the F sample.
    step(1, 4'h0); step(1, 4'hA); step(1, 4'h2); step(1, 4'hE);
    step(1, 4'h4); step(1, 4'hD); step(1, 4'h5); step(1, 4'hF);
    chk("solve_pre_done", done_a, 0);
    chk("solve_pre_moves", moves_a, 6);
    settle();
    chk("solve_status", status_a, 2);
    chk("solve_done", done_a, 1);
    chk("solve_err_code", err_code_a, 0);
    chk("solve_moves", moves_a, 7);
    chk("solve_b_budget_err", err_code_b, 3);
    chk("solve_b_moves", moves_b, 3);
    step(1, 4'h0); settle();
    chk("done_frozen_status", status_a, 2);
    chk("done_frozen_moves", moves_a, 7);

    // Farmer takes the wolf: sheep and cabbage left alone.
    do_reset(1'b0, 1'b1);
    step(1, 4'h0); step(1, 4'hC); settle();
    chk("eaten_status", status_a, 3);
    chk("eaten_err_code", err_code_a, 2);
    chk("eaten_moves", moves_a, 0);
    step(1, 4'h0); settle();
    chk("eaten_frozen_status", status_a, 3);
    chk("eaten_frozen_err", err_code_a, 2);

    // Clear out of FAIL, then two items move without the farmer.
    do_reset(1'b1, 1'b0);
    chk("clear_from_fail", status_a, 0);
    step(1, 4'h0); step(1, 4'h3); settle();
    chk("illegal3_err_code", err_code_a, 1);
    chk("illegal3_moves", moves_a, 0);

    do_reset(1'b0, 1'b1);
    step(1, 4'h0); step(1, 4'hA); step(1, 4'hB); settle();
    chk("illegalB_err_code", err_code_a, 1);
    chk("illegalB_moves", moves_a, 1);

    // Budget of 3 on dut_b using the sheep shuttle (0->8 would leave wolf with sheep).
    do_reset(1'b0, 1'b1);
    step(1, 4'h0); step(1, 4'hA); step(1, 4'hA); step(1, 4'hA);
    chk("hold_no_count", moves_b, 1);
    step(1, 4'h2); step(1, 4'hA); settle();
    chk("budget_err_code", err_code_b, 3);
    chk("budget_moves", moves_b, 3);
    chk("budget_a_status", status_a, 1);

    do_reset(1'b0, 1'b1);
    step(1, 4'h0); step(0, 4'hA); step(1, 4'hA); step(0, 4'h2); step(0, 4'hF);
    step(1, 4'h2); step(0, 4'h0); step(1, 4'hA); settle();
    chk("budget_gap_err_code", err_code_b, 3);
    chk("budget_gap_moves", moves_b, 3);

    // Clear mid-run drops the count; a sample during clear is ignored.
    do_reset(1'b0, 1'b1);
    step(1, 4'h0); step(1, 4'hA); step(1, 4'h2); settle();
    chk("pre_clear_moves", moves_a, 2);
    @(negedge clk);
    clear = 1'b1; en = 1'b1; state_in = 4'hE;
    @(negedge clk);
    clear = 1'b0; en = 1'b0;
    chk("clear_status", status_a, 0);
    chk("clear_moves", moves_a, 0);
    step(1, 4'h0); step(1, 4'hA); settle();
    chk("after_clear_status", status_a, 1);
    chk("after_clear_moves", moves_a, 1);
    do_reset(1'b1, 1'b1);
    chk("rst_clear_status", status_a, 0);
    chk("rst_clear_moves", moves_a, 0);

    // Return to the start bank.
    step(1, 4'h0); step(1, 4'hA); step(1, 4'h0); settle();
    chk("revisit_status", status_a, 1);
    chk("revisit_moves", moves_a, 2);
`ifdef WSC_MON_REVISIT_EN
    chk("revisit_flag", revisit_a, 1);
`else
    chk("revisit_flag", revisit_a, 0);
`endif

    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
